// File: rtl/data_mem_resp.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : data_mem_resp
// Description : MEM-stage data memory responder. Latches one request, waits
//               WAIT_STATES cycles, completes it and pulses mem_ready.
//               Optional MMIO debug register at 16'hFFFF (DMEM_MMIO_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        mem_err
`ifdef DMEM_MMIO_EN
    ,
    output logic [15:0] dbg_out
`endif
);

    localparam int         c_WORDS = 1 << DEPTH_LOG2;
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;
    localparam logic [2:0] c_WS    = 3'(WAIT_STATES);

    logic [1:0]            r_state;
    logic [2:0]            r_cnt;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_err;
    logic [DEPTH_LOG2-1:0] r_addr;
    logic [15:0]           r_wdata;
    logic [15:0]           r_mem [0:c_WORDS-1];

    logic                  w_out_of_range;
    logic                  w_req_err;
    logic                  w_do_write;

    assign w_out_of_range = (mem_addr[15:DEPTH_LOG2] != '0);

`ifdef DMEM_MMIO_EN
    logic r_mmio;
    logic w_mmio;

    assign w_mmio     = (mem_addr == 16'hFFFF);
    assign w_req_err  = (mem_rd & mem_wr) | (w_out_of_range & ~w_mmio);
    assign w_do_write = (r_state == c_DONE) & r_wr & ~r_err & ~r_mmio;
`else
    assign w_req_err  = (mem_rd & mem_wr) | w_out_of_range;
    assign w_do_write = (r_state == c_DONE) & r_wr & ~r_err;
`endif

    // Array has no reset; an aborted access never reaches DONE, so no write.
    always_ff @(posedge clk) begin
        if (w_do_write) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 3'd0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= 16'h0000;
            mem_rdata <= 16'h0000;
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
`ifdef DMEM_MMIO_EN
            r_mmio    <= 1'b0;
            dbg_out   <= 16'h0000;
`endif
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (mem_rd | mem_wr) begin
                        r_rd    <= mem_rd;
                        r_wr    <= mem_wr;
                        r_err   <= w_req_err;
                        r_addr  <= mem_addr[DEPTH_LOG2-1:0];
                        r_wdata <= mem_wdata;
                        r_cnt   <= c_WS;
`ifdef DMEM_MMIO_EN
                        r_mmio  <= w_mmio;
`endif
                        r_state <= (WAIT_STATES == 0) ? c_DONE : c_WAIT;
                    end
                end
                c_WAIT: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    mem_ready <= 1'b1;
                    mem_err   <= r_err;
                    r_state   <= c_IDLE;
                    if (r_err) begin
                        mem_rdata <= 16'h0000;
`ifdef DMEM_MMIO_EN
                    end else if (r_mmio) begin
                        if (r_wr) begin
                            dbg_out <= r_wdata;
                        end
                        if (r_rd) begin
                            mem_rdata <= dbg_out;
                        end
`endif
                    end else if (r_rd) begin
                        mem_rdata <= r_mem[r_addr];
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
